// File: rtl/ucb_sched_pkg.sv
// Shared types and helpers for the UCB arm scheduler: FSM state encoding and
// the fp32 total-order key used to rank UCB indices with an unsigned compare.
package ucb_sched_pkg;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      INIT        = 3'd1,
      WAIT_IDX    = 3'd2,
      SCAN        = 3'd3,
      ISSUE       = 3'd4,
      WAIT_REWARD = 3'd5,
      DONE        = 3'd6
   } sched_state_e;

   localparam logic [7:0] FP32_NAN_EXP = 8'hFF;

   // Positive floats get the top bit set so they sort above all negatives;
   // negatives are fully inverted so larger magnitude sorts lower. NaN maps to 0.
   function automatic logic [31:0] fp32_order_key(input logic [31:0] bits);
      logic [31:0] key;
      if ((bits[30:23] == FP32_NAN_EXP) && (bits[22:0] != 23'd0)) begin
         key = 32'd0;
      end else if (!bits[31]) begin
         key = {1'b1, bits[30:0]};
      end else begin
         key = ~bits;
      end
      return key;
   endfunction

endpackage

// File: rtl/ucb_fp32_max_scan.sv
// Sequential argmax over N_ARMS fp32 indices, one arm per cycle after start_i.
// best_arm_o/best_key_o carry the running result including the current arm.
module ucb_fp32_max_scan
   import ucb_sched_pkg::*;
#(
   parameter int N_ARMS = 2,
   parameter int ARM_W  = 1
) (
   input  logic                  clk,
   input  logic                  s_aresetn,
   input  logic                  start_i,
   input  logic [32*N_ARMS-1:0]  idx_i,
   output logic                  done_o,
   output logic [ARM_W-1:0]      best_arm_o,
   output logic [31:0]           best_key_o
);

   localparam logic [ARM_W-1:0] LAST_ARM = ARM_W'(N_ARMS - 1);

   logic             active_q, active_d;
   logic [ARM_W-1:0] k_q, k_d;
   logic [ARM_W-1:0] best_arm_q, best_arm_d;
   logic [31:0]      best_key_q, best_key_d;
   logic [31:0]      cur_key;
   logic             last;

   always_comb begin
      active_d   = active_q;
      k_d        = k_q;
      best_arm_d = best_arm_q;
      best_key_d = best_key_q;
      cur_key    = fp32_order_key(idx_i[32*int'(k_q) +: 32]);
      last       = active_q && (k_q == LAST_ARM);

      if (start_i) begin
         active_d = 1'b1;
         k_d      = '0;
      end else if (active_q) begin
         // Arm 0 always seeds the result; later arms need a strictly larger key.
         if ((k_q == '0) || (cur_key > best_key_q)) begin
            best_arm_d = k_q;
            best_key_d = cur_key;
         end
         if (last) begin
            active_d = 1'b0;
         end else begin
            k_d = k_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge s_aresetn) begin
      if (!s_aresetn) begin
         active_q   <= 1'b0;
         k_q        <= '0;
         best_arm_q <= '0;
         best_key_q <= '0;
      end else begin
         active_q   <= active_d;
         k_q        <= k_d;
         best_arm_q <= best_arm_d;
         best_key_q <= best_key_d;
      end
   end

   assign done_o     = last;
   assign best_arm_o = best_arm_d;
   assign best_key_o = best_key_d;

endmodule

// File: rtl/ucb_arm_scheduler.sv
// Round controller for the UCB bandit engine: pulls every arm once, then pulls
// the arm with the highest fp32 UCB index each round until num_rounds pulls.
module ucb_arm_scheduler
   import ucb_sched_pkg::*;
#(
   parameter int N_ARMS = 2,
   parameter int ARM_W  = 1,
   parameter int CNT_W  = 16
) (
   input  logic                      clk,
   input  logic                      s_aresetn,
   input  logic                      start,
   input  logic [CNT_W-1:0]          num_rounds,
   input  logic [32*N_ARMS-1:0]      idx_in,
   input  logic [N_ARMS-1:0]         idx_valid,
   output logic                      pull_valid,
   input  logic                      pull_ready,
   output logic [ARM_W-1:0]          pull_arm,
   input  logic                      reward_valid,
   output logic                      busy,
   output logic                      done,
   output logic [CNT_W-1:0]          round_cnt,
   output logic [CNT_W*N_ARMS-1:0]   pull_cnt,
   output logic [2:0]                state_dbg
);

   localparam logic [CNT_W:0] N_ARMS_EXT = (CNT_W + 1)'(N_ARMS);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   sched_state_e     state_q, state_d;
   logic [CNT_W-1:0] num_rounds_q, num_rounds_d;
   logic [CNT_W-1:0] round_cnt_q, round_cnt_d;
   logic [ARM_W-1:0] pull_arm_q, pull_arm_d;
   logic [CNT_W-1:0] pull_cnt_q [N_ARMS];
   logic [CNT_W-1:0] pull_cnt_d [N_ARMS];
   logic [CNT_W:0]   round_nxt;

   logic             scan_start;
   logic             scan_done;
   logic [ARM_W-1:0] scan_best_arm;
   logic [31:0]      scan_best_key;
   logic             unused_scan_key;

   ucb_fp32_max_scan #(
      .N_ARMS (N_ARMS),
      .ARM_W  (ARM_W)
   ) u_scan (
      .clk        (clk),
      .s_aresetn  (s_aresetn),
      .start_i    (scan_start),
      .idx_i      (idx_in),
      .done_o     (scan_done),
      .best_arm_o (scan_best_arm),
      .best_key_o (scan_best_key)
   );

   assign unused_scan_key = ^scan_best_key;

   // Pull handshake: pull_valid is high exactly while in ISSUE, pull_arm is
   // frozen there, and the edge that sees pull_valid && pull_ready is the transfer.
   always_comb begin
      state_d      = state_q;
      num_rounds_d = num_rounds_q;
      round_cnt_d  = round_cnt_q;
      pull_arm_d   = pull_arm_q;
      pull_cnt_d   = pull_cnt_q;
      scan_start   = 1'b0;
      round_nxt    = {1'b0, round_cnt_q} + 1'b1;

      case (state_q)
         IDLE: begin
            if (start) begin
               num_rounds_d = num_rounds;
               round_cnt_d  = '0;
               pull_arm_d   = '0;
               for (int k = 0; k < N_ARMS; k++) pull_cnt_d[k] = '0;
               state_d = (num_rounds == '0) ? DONE : INIT;
            end
         end
         INIT: begin
            if ({1'b0, round_cnt_q} >= N_ARMS_EXT) begin
               state_d = WAIT_IDX;
            end else begin
               pull_arm_d = round_cnt_q[ARM_W-1:0];
               state_d    = ISSUE;
            end
         end
         WAIT_IDX: begin
            if (&idx_valid) begin
               scan_start = 1'b1;
               state_d    = SCAN;
            end
         end
         SCAN: begin
            if (scan_done) begin
               pull_arm_d = scan_best_arm;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            if (pull_ready) state_d = WAIT_REWARD;
         end
         WAIT_REWARD: begin
            if (reward_valid) begin
               round_cnt_d            = sat_inc(round_cnt_q);
               pull_cnt_d[pull_arm_q] = sat_inc(pull_cnt_q[pull_arm_q]);
               if (round_nxt == {1'b0, num_rounds_q}) begin
                  state_d = DONE;
               end else if (round_nxt < N_ARMS_EXT) begin
                  state_d = INIT;
               end else begin
                  state_d = WAIT_IDX;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge s_aresetn) begin
      if (!s_aresetn) begin
         state_q      <= IDLE;
         num_rounds_q <= '0;
         round_cnt_q  <= '0;
         pull_arm_q   <= '0;
         for (int k = 0; k < N_ARMS; k++) pull_cnt_q[k] <= '0;
      end else begin
         state_q      <= state_d;
         num_rounds_q <= num_rounds_d;
         round_cnt_q  <= round_cnt_d;
         pull_arm_q   <= pull_arm_d;
         pull_cnt_q   <= pull_cnt_d;
      end
   end

   assign pull_valid = (state_q == ISSUE);
   assign pull_arm   = pull_arm_q;
   assign busy       = (state_q != IDLE) && (state_q != DONE);
   assign done       = (state_q == DONE);
   assign round_cnt  = round_cnt_q;
   assign state_dbg  = state_q;

   for (genvar g = 0; g < N_ARMS; g++) begin : g_pull_cnt
      assign pull_cnt[CNT_W*g +: CNT_W] = pull_cnt_q[g];
   end

endmodule

// File: tb/tb_ucb_arm_scheduler.sv
// Directed bench for ucb_arm_scheduler with 4 arms: init round-robin, table of
// argmax vectors, backpressure, idx_valid gating, zero-round run, async reset.
module tb_ucb_arm_scheduler;

   localparam int N_ARMS = 4;
   localparam int ARM_W  = 2;
   localparam int CNT_W  = 16;

   // clock / reset
   logic clk = 1'b0;
   logic s_aresetn = 1'b0;
   always #5 clk = ~clk;

   logic                      start = 1'b0;
   logic [CNT_W-1:0]          num_rounds = '0;
   logic [32*N_ARMS-1:0]      idx_in = '0;
   logic [N_ARMS-1:0]         idx_valid = '0;
   logic                      pull_valid;
   logic                      pull_ready = 1'b0;
   logic [ARM_W-1:0]          pull_arm;
   logic                      reward_valid = 1'b0;
   logic                      busy;
   logic                      done;
   logic [CNT_W-1:0]          round_cnt;
   logic [CNT_W*N_ARMS-1:0]   pull_cnt;
   logic [2:0]                state_dbg;

   ucb_arm_scheduler #(
      .N_ARMS (N_ARMS),
      .ARM_W  (ARM_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk          (clk),
      .s_aresetn    (s_aresetn),
      .start        (start),
      .num_rounds   (num_rounds),
      .idx_in       (idx_in),
      .idx_valid    (idx_valid),
      .pull_valid   (pull_valid),
      .pull_ready   (pull_ready),
      .pull_arm     (pull_arm),
      .reward_valid (reward_valid),
      .busy         (busy),
      .done         (done),
      .round_cnt    (round_cnt),
      .pull_cnt     (pull_cnt),
      .state_dbg    (state_dbg)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [ARM_W-1:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] pack_cnt(input int c0, input int c1, input int c2, input int c3);
      return {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
   endfunction

   // Every transfer must match the next arm the test expects.
   always @(negedge clk) begin
      if (s_aresetn && pull_valid && pull_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_transfer", 64'(pull_arm) + 64'd100, 64'd0);
         end else begin
            check("transfer_arm", 64'(pull_arm), 64'(exp_q.pop_front()));
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input int rounds);
      num_rounds = CNT_W'(rounds);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Wait for pull_valid, hold off pull_ready for ready_delay cycles,
   // accept, then return the reward two cycles after the transfer.
   task automatic run_pull(input logic [ARM_W-1:0] exp_arm, input int ready_delay, output int waited);
      waited = 0;
      while (!pull_valid && waited < 60) begin
         tick();
         waited++;
      end
      check("pull_valid_wait", 64'(pull_valid), 64'd1);
      if (!pull_valid) return;
      check("pull_arm", 64'(pull_arm), 64'(exp_arm));
      exp_q.push_back(exp_arm);
      for (int i = 0; i < ready_delay; i++) begin
         tick();
         check("bp_valid_held", 64'(pull_valid), 64'd1);
         check("bp_arm_held", 64'(pull_arm), 64'(exp_arm));
      end
      pull_ready = 1'b1;
      tick();
      pull_ready = 1'b0;
      check("valid_drop", 64'(pull_valid), 64'd0);
      tick();
      reward_valid = 1'b1;
      tick();
      reward_valid = 1'b0;
   endtask

   task automatic check_done(input int rounds, input logic [63:0] exp_pc);
      check("done_pulse", 64'(done), 64'd1);
      check("busy_at_done", 64'(busy), 64'd0);
      check("round_cnt", 64'(round_cnt), 64'(rounds));
      check("pull_cnt", 64'(pull_cnt), exp_pc);
      tick();
      check("done_one_cycle", 64'(done), 64'd0);
      check("counters_hold", 64'(round_cnt), 64'(rounds));
   endtask

   typedef struct {
      logic [127:0]     idx;
      logic [ARM_W-1:0] exp_arm;
   } vec_t;

   vec_t vecs[7];

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int w;
      int pc[4];

      // idx packed as {arm3, arm2, arm1, arm0}
      vecs[0] = '{idx: {32'h40600000, 32'hC0000000, 32'h40600000, 32'h3F800000}, exp_arm: 2'd1};
      vecs[1] = '{idx: {32'hC0400000, 32'hBF000000, 32'hBF800000, 32'h7FC00000}, exp_arm: 2'd2};
      vecs[2] = '{idx: {32'h7F800001, 32'hFFC00000, 32'h7FC00001, 32'h7FC00000}, exp_arm: 2'd0};
      vecs[3] = '{idx: {32'h00000001, 32'hFF800000, 32'h80000000, 32'h00000000}, exp_arm: 2'd3};
      vecs[4] = '{idx: {32'h7F800000, 32'h7E967699, 32'h7FC00000, 32'h7F800000}, exp_arm: 2'd0};
      vecs[5] = '{idx: {32'hFF800000, 32'h80000001, 32'h80000000, 32'hC0A00000}, exp_arm: 2'd1};
      vecs[6] = '{idx: {32'h41000000, 32'h40800000, 32'h40000000, 32'h3F800000}, exp_arm: 2'd3};

      // reset state
      tick();
      tick();
      check("rst_pull_valid", 64'(pull_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_round_cnt", 64'(round_cnt), 64'd0);
      check("rst_pull_cnt", 64'(pull_cnt), 64'd0);
      check("rst_state", 64'(state_dbg), 64'd0);
      #4 s_aresetn = 1'b1;
      tick();

      // zero-round run: done the cycle after start, no pull
      start_run(0);
      check("zero_done", 64'(done), 64'd1);
      check("zero_no_pull", 64'(pull_valid), 64'd0);
      check("zero_busy", 64'(busy), 64'd0);
      tick();
      check("zero_done_clear", 64'(done), 64'd0);
      check("zero_pull_valid", 64'(pull_valid), 64'd0);

      // init phase only, indices never valid; start during busy is ignored
      idx_valid = '0;
      start_run(4);
      check("busy_after_start", 64'(busy), 64'd1);
      run_pull(2'd0, 0, w);
      num_rounds = 16'd9;
      start = 1'b1;
      tick();
      start = 1'b0;
      num_rounds = 16'd4;
      for (int k = 1; k < 4; k++) run_pull(ARM_W'(k), 0, w);
      check_done(4, pack_cnt(1, 1, 1, 1));

      // argmax table: 4 init pulls then one UCB pull
      for (int v = 0; v < 7; v++) begin
         idx_in = vecs[v].idx;
         idx_valid = 4'hF;
         start_run(5);
         for (int k = 0; k < 4; k++) run_pull(ARM_W'(k), 0, w);
         run_pull(vecs[v].exp_arm, 0, w);
         check("reward_to_pull_latency", 64'(w + 1), 64'(1 + N_ARMS + 1));
         pc = '{1, 1, 1, 1};
         pc[vecs[v].exp_arm] = 2;
         check_done(5, pack_cnt(pc[0], pc[1], pc[2], pc[3]));
      end

      // backpressure: 10 cycles of pull_ready=0, single transfer
      start_run(1);
      run_pull(2'd0, 10, w);
      check_done(1, pack_cnt(1, 0, 0, 0));

      // idx_valid gating: stays in WAIT_IDX until the last arm is valid
      idx_in = vecs[6].idx;
      idx_valid = 4'b0111;
      start_run(5);
      for (int k = 0; k < 4; k++) run_pull(ARM_W'(k), 0, w);
      for (int i = 0; i < 8; i++) begin
         check("gate_state", 64'(state_dbg), 64'd2);
         check("gate_no_pull", 64'(pull_valid), 64'd0);
         tick();
      end
      idx_valid = 4'hF;
      run_pull(2'd3, 0, w);
      check_done(5, pack_cnt(1, 1, 1, 2));

      // async reset while a pull is pending in ISSUE
      idx_valid = '0;
      start_run(5);
      run_pull(2'd0, 0, w);
      run_pull(2'd1, 0, w);
      w = 0;
      while (!pull_valid && w < 60) begin
         tick();
         w++;
      end
      check("pre_reset_pull_valid", 64'(pull_valid), 64'd1);
      #2 s_aresetn = 1'b0;
      #1;
      check("arst_pull_valid", 64'(pull_valid), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_done", 64'(done), 64'd0);
      check("arst_round_cnt", 64'(round_cnt), 64'd0);
      check("arst_pull_cnt", 64'(pull_cnt), 64'd0);
      #1 s_aresetn = 1'b1;
      tick();
      tick();
      check("post_reset_idle", 64'(state_dbg), 64'd0);
      check("post_reset_no_pull", 64'(pull_valid), 64'd0);

      // final report
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
